// File: rtl/quiz_round_arbiter.sv
// Quiz round controller and round-robin buzzer arbiter with countdown, judging, scores and beeper.
// Optional build macro FALSE_START_PENALTY_EN: a player already buzzing at round start sits the round out.
module quiz_round_arbiter #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned ALARM_CYCLES = 20000000
) (
  input  logic        clk,
  input  logic        begining,
  input  logic        count_down,
  input  logic        time_select,
  input  logic [3:0]  answer,
  input  logic        Yes,
  input  logic        No,
  input  logic        select1,
  input  logic        select2,
  output logic [3:0]  answer_led,
  output logic        getter,
  output logic [4:0]  remaining,
  output logic [1:0]  phase,
  output logic [15:0] scores,
  output logic        alarm
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam int unsigned SW = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_LOCKED = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Synchronizer bit map: [3:0] answer, 4 start, 5 yes, 6 no, 7 time_select, 8 select1, 9 select2
  logic [SW-1:0] r_sync1, r_sync2;
  logic [2:0]    r_edge_d;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_remaining, w_remaining_nxt;
  logic [3:0]    r_enable, w_enable_nxt;
  logic [3:0]    r_excl, w_excl_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [1:0]    r_win, w_win_nxt;
  logic [3:0]    r_led, w_led_nxt;
  logic          r_getter, w_getter_nxt;
  logic [15:0]   r_scores, w_scores_nxt;
  logic          r_alarm, w_alarm_nxt;
  logic [AW-1:0] r_alarm_cnt, w_alarm_cnt_nxt;

  logic          w_cd_rise, w_yes_rise, w_no_rise, w_tick, w_alarm_trig;
  logic [3:0]    w_elig, w_en_sel, w_win_oh, w_cur_score;
  logic [1:0]    w_win_idx;

  assign w_cd_rise  = r_sync2[4] & ~r_edge_d[0];
  assign w_yes_rise = r_sync2[5] & ~r_edge_d[1];
  assign w_no_rise  = r_sync2[6] & ~r_edge_d[2];
  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_elig     = r_sync2[3:0] & r_enable & ~r_excl;
  assign w_win_oh   = 4'b0001 << w_win_idx;
  assign w_cur_score = r_scores[{r_win, 2'b00} +: 4];

  always_comb begin
    unique case (r_sync2[9:8])
      2'b00:   w_en_sel = 4'b0011;
      2'b01:   w_en_sel = 4'b0111;
      default: w_en_sel = 4'b1111;
    endcase
  end

  // Round-robin pick: scan from lowest priority to highest so the pointer's player wins last
  always_comb begin
    w_win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[2'(r_ptr + 2'(i))]) w_win_idx = 2'(r_ptr + 2'(i));
    end
  end

  always_ff @(posedge clk or negedge begining) begin
    if (!begining) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_edge_d    <= '0;
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_enable    <= '0;
      r_excl      <= '0;
      r_presc     <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
      r_led       <= '0;
      r_getter    <= 1'b0;
      r_scores    <= '0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_sync1     <= {select2, select1, time_select, No, Yes, count_down, answer};
      r_sync2     <= r_sync1;
      r_edge_d    <= r_sync2[6:4];
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_enable    <= w_enable_nxt;
      r_excl      <= w_excl_nxt;
      r_presc     <= w_presc_nxt;
      r_ptr       <= w_ptr_nxt;
      r_win       <= w_win_nxt;
      r_led       <= w_led_nxt;
      r_getter    <= w_getter_nxt;
      r_scores    <= w_scores_nxt;
      r_alarm     <= w_alarm_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_enable_nxt    = r_enable;
    w_excl_nxt      = r_excl;
    w_presc_nxt     = r_presc;
    w_ptr_nxt       = r_ptr;
    w_win_nxt       = r_win;
    w_led_nxt       = r_led;
    w_getter_nxt    = r_getter;
    w_scores_nxt    = r_scores;
    w_alarm_trig    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_cd_rise) begin
          w_state_nxt     = S_ARMED;
          w_remaining_nxt = r_sync2[7] ? 5'd30 : 5'd20;
          w_enable_nxt    = w_en_sel;
`ifdef FALSE_START_PENALTY_EN
          w_excl_nxt      = r_sync2[3:0] & w_en_sel;
`else
          w_excl_nxt      = 4'b0000;
`endif
          w_presc_nxt     = '0;
          w_led_nxt       = 4'b0000;
        end
      end
      S_ARMED: begin
        w_presc_nxt = w_tick ? '0 : PW'(r_presc + 1'b1);
        // A buzz beats a coincident tick; that tick is simply lost
        if (|w_elig) begin
          w_state_nxt  = S_LOCKED;
          w_win_nxt    = w_win_idx;
          w_led_nxt    = w_win_oh;
          w_getter_nxt = 1'b1;
          w_ptr_nxt    = 2'(w_win_idx + 2'd1);
          w_alarm_trig = 1'b1;
        end else if (w_tick) begin
          w_remaining_nxt = 5'(r_remaining - 5'd1);
          if (r_remaining == 5'd1) begin
            w_state_nxt  = S_DONE;
            w_alarm_trig = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (w_yes_rise && !w_no_rise) begin
          if (w_cur_score != 4'hF) w_scores_nxt[{r_win, 2'b00} +: 4] = 4'(w_cur_score + 4'd1);
          w_state_nxt  = S_DONE;
          w_getter_nxt = 1'b0;
        end else if (w_no_rise && !w_yes_rise) begin
          w_excl_nxt   = r_excl | r_led;
          w_getter_nxt = 1'b0;
          w_led_nxt    = 4'b0000;
          if (((r_excl | r_led) & r_enable) == r_enable) begin
            w_state_nxt  = S_DONE;
            w_alarm_trig = 1'b1;
          end else begin
            w_state_nxt = S_ARMED;
          end
        end
      end
      S_DONE: begin
        if (!r_sync2[4]) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beeper pulse; a retrigger reloads the full length
  always_comb begin
    w_alarm_nxt     = r_alarm;
    w_alarm_cnt_nxt = r_alarm_cnt;
    if (w_alarm_trig) begin
      w_alarm_nxt     = 1'b1;
      w_alarm_cnt_nxt = AW'(ALARM_CYCLES - 1);
    end else if (r_alarm) begin
      if (r_alarm_cnt == '0) w_alarm_nxt = 1'b0;
      else                   w_alarm_cnt_nxt = AW'(r_alarm_cnt - 1'b1);
    end
  end

  assign answer_led = r_led;
  assign getter     = r_getter;
  assign remaining  = r_remaining;
  assign phase      = r_state;
  assign scores     = r_scores;
  assign alarm      = r_alarm;

endmodule
